// File: rtl/compare_window_stats_if.sv
// compare_window_stats_if
//   Sample stream and report bundle for compare_window_stats.
//   Sample side : in_valid / in_ready plus the one-hot flags
//                 a_greater / a_equal / a_less.
//   Report side : out_valid / out_ready plus gt/eq/lt/err counts and verdict.
//   master : producer of samples and consumer of reports.
//   slave  : the statistics block.
interface compare_window_stats_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             a_greater;
    logic             a_equal;
    logic             a_less;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] gt_count;
    logic [CNT_W-1:0] eq_count;
    logic [CNT_W-1:0] lt_count;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       verdict;

    modport master (
        output in_valid, a_greater, a_equal, a_less, out_ready,
        input  in_ready, out_valid, gt_count, eq_count, lt_count, err_count, verdict
    );

    modport slave (
        input  in_valid, a_greater, a_equal, a_less, out_ready,
        output in_ready, out_valid, gt_count, eq_count, lt_count, err_count, verdict
    );
endinterface

// File: rtl/compare_window_stats.sv
// compare_window_stats
//   Counts comparator outcomes over a window of WINDOW accepted samples and
//   then holds one report record (counts + majority verdict) until taken.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high
//   bus  - compare_window_stats_if.slave (sample stream in, report out)
// Verdict encoding: 00 equal, 01 greater, 10 less, 11 no one-hot samples.
//
// state  | meaning
// -------+---------------------------------------------------------------
// ACCUM  | accepting samples, counts track the running window
// REPORT | window complete, outputs frozen until out_ready
module compare_window_stats #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    compare_window_stats_if.slave  bus
);

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] ZERO     = '0;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] smp_cnt;
    logic [CNT_W-1:0] gt_q, eq_q, lt_q, err_q;
    logic [CNT_W-1:0] gt_nxt, eq_nxt, lt_nxt, err_nxt;
    logic [1:0]       verdict_q;
    logic             in_rdy;
    logic             accept;
    logic             last_smp;
    logic             take_rep;
    logic             is_gt, is_eq, is_lt, is_err;

    function automatic logic [1:0] pick_verdict(
        input logic [CNT_W-1:0] gt,
        input logic [CNT_W-1:0] eq,
        input logic [CNT_W-1:0] lt
    );
        logic [1:0] v;
        // Tie priority falls out of the compare order: equal, then greater.
        if (gt == ZERO && eq == ZERO && lt == ZERO) v = 2'b11;
        else if (eq >= gt && eq >= lt)              v = 2'b00;
        else if (gt >= lt)                          v = 2'b01;
        else                                        v = 2'b10;
        return v;
    endfunction

    // in_ready depends on registered state only.
    assign in_rdy   = (state_q == ACCUM);
    assign accept   = bus.in_valid && in_rdy;
    assign last_smp = (smp_cnt == LAST_IDX);
    assign take_rep = (state_q == REPORT) && bus.out_ready;

    assign is_gt  = ({bus.a_greater, bus.a_equal, bus.a_less} == 3'b100);
    assign is_eq  = ({bus.a_greater, bus.a_equal, bus.a_less} == 3'b010);
    assign is_lt  = ({bus.a_greater, bus.a_equal, bus.a_less} == 3'b001);
    assign is_err = !(is_gt || is_eq || is_lt);

    assign gt_nxt  = gt_q  + {{(CNT_W-1){1'b0}}, is_gt};
    assign eq_nxt  = eq_q  + {{(CNT_W-1){1'b0}}, is_eq};
    assign lt_nxt  = lt_q  + {{(CNT_W-1){1'b0}}, is_lt};
    assign err_nxt = err_q + {{(CNT_W-1){1'b0}}, is_err};

    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && last_smp) state_d = REPORT;
            REPORT:  if (bus.out_ready)      state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        bus.in_ready  = in_rdy;
        bus.out_valid = (state_q == REPORT);
    end

    // Taking the report clears everything on the same edge so a fresh
    // window can start the cycle after.
    always_ff @(posedge clk) begin
        if (rst || take_rep) begin
            smp_cnt   <= '0;
            gt_q      <= '0;
            eq_q      <= '0;
            lt_q      <= '0;
            err_q     <= '0;
            verdict_q <= 2'b11;
        end else if (accept) begin
            smp_cnt <= smp_cnt + 1'b1;
            gt_q    <= gt_nxt;
            eq_q    <= eq_nxt;
            lt_q    <= lt_nxt;
            err_q   <= err_nxt;
            if (last_smp) verdict_q <= pick_verdict(gt_nxt, eq_nxt, lt_nxt);
        end
    end

    assign bus.gt_count  = gt_q;
    assign bus.eq_count  = eq_q;
    assign bus.lt_count  = lt_q;
    assign bus.err_count = err_q;
    assign bus.verdict   = verdict_q;

endmodule

// File: tb/tb_compare_window_stats.sv
// tb_compare_window_stats
//   Three instances (WINDOW = 8, 4, 1) share one stimulus driver; sel picks
//   which instance receives in_valid and whose outputs are observed.
//   Expected reports are queued as windows are driven and popped when the
//   observed instance completes a report handshake.
module tb_compare_window_stats;

    localparam int CW = 8;

    logic clk;
    logic rst;
    logic drv_valid;
    logic [2:0] drv_f;
    logic out_ready;
    int sel;

    logic          obs_in_ready, obs_out_valid;
    logic [CW-1:0] obs_gt, obs_eq, obs_lt, obs_err;
    logic [1:0]    obs_vd;
    int            obs_win;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    int cyc = 0;

    compare_window_stats_if #(.CNT_W(CW)) if8 ();
    compare_window_stats_if #(.CNT_W(CW)) if4 ();
    compare_window_stats_if #(.CNT_W(CW)) if1 ();

    compare_window_stats #(.CNT_W(CW), .WINDOW(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    compare_window_stats #(.CNT_W(CW), .WINDOW(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    compare_window_stats #(.CNT_W(CW), .WINDOW(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    assign if8.in_valid = drv_valid && (sel == 0);
    assign if4.in_valid = drv_valid && (sel == 1);
    assign if1.in_valid = drv_valid && (sel == 2);
    assign {if8.a_greater, if8.a_equal, if8.a_less} = drv_f;
    assign {if4.a_greater, if4.a_equal, if4.a_less} = drv_f;
    assign {if1.a_greater, if1.a_equal, if1.a_less} = drv_f;
    assign if8.out_ready = out_ready;
    assign if4.out_ready = out_ready;
    assign if1.out_ready = out_ready;

    always_comb begin
        obs_in_ready = if8.in_ready;  obs_out_valid = if8.out_valid;
        obs_gt = if8.gt_count;  obs_eq = if8.eq_count;
        obs_lt = if8.lt_count;  obs_err = if8.err_count;
        obs_vd = if8.verdict;   obs_win = 8;
        if (sel == 1) begin
            obs_in_ready = if4.in_ready;  obs_out_valid = if4.out_valid;
            obs_gt = if4.gt_count;  obs_eq = if4.eq_count;
            obs_lt = if4.lt_count;  obs_err = if4.err_count;
            obs_vd = if4.verdict;   obs_win = 4;
        end else if (sel == 2) begin
            obs_in_ready = if1.in_ready;  obs_out_valid = if1.out_valid;
            obs_gt = if1.gt_count;  obs_eq = if1.eq_count;
            obs_lt = if1.lt_count;  obs_err = if1.err_count;
            obs_vd = if1.verdict;   obs_win = 1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int gt, eq, lt, err, vd;
    } exp_t;

    typedef struct {
        int          sel;
        int          n;
        logic [23:0] f;
        exp_t        e;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[9];

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    function automatic logic [23:0] pk8(
        input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] s3,
        input logic [2:0] s4, input logic [2:0] s5, input logic [2:0] s6, input logic [2:0] s7
    );
        return {s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    function automatic exp_t mk(input int gt, input int eq, input int lt, input int err, input int vd);
        exp_t e;
        e.gt = gt; e.eq = eq; e.lt = lt; e.err = err; e.vd = vd;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && drv_valid && obs_in_ready) hs_cnt++;
        if (!rst && obs_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_report", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rep_gt",  int'(obs_gt),  e.gt);
                chk("rep_eq",  int'(obs_eq),  e.eq);
                chk("rep_lt",  int'(obs_lt),  e.lt);
                chk("rep_err", int'(obs_err), e.err);
                chk("rep_verdict", int'(obs_vd), e.vd);
                chk("rep_sum", int'(obs_gt) + int'(obs_eq) + int'(obs_lt) + int'(obs_err), obs_win);
            end
        end
    end

    // Present one sample and hold it until accepted; returns accept cycle.
    task automatic send(input logic [2:0] f, output int acc_cyc);
        bit done;
        int k;
        drv_valid = 1'b1;
        drv_f     = f;
        done      = 1'b0;
        k         = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            if (obs_in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        acc_cyc = cyc;
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int k;
        drv_valid = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int ac, prev_ac, h0, nsel, n;
        logic [2:0] f;

        vt[0] = '{0, 8, pk8(3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100),
                  mk(8, 0, 0, 0, 1)};
        vt[1] = '{0, 8, pk8(3'b010, 3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b001),
                  mk(2, 3, 3, 0, 0)};
        vt[2] = '{0, 8, pk8(3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b110),
                  mk(0, 0, 6, 2, 2)};
        vt[3] = '{0, 8, pk8(3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010),
                  mk(3, 2, 3, 0, 1)};
        vt[4] = '{1, 4, pk8(3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000),
                  mk(0, 0, 0, 4, 3)};
        vt[5] = '{2, 1, {21'd0, 3'b100}, mk(1, 0, 0, 0, 1)};
        vt[6] = '{2, 1, {21'd0, 3'b010}, mk(0, 1, 0, 0, 0)};
        vt[7] = '{2, 1, {21'd0, 3'b001}, mk(0, 0, 1, 0, 2)};
        vt[8] = '{2, 1, {21'd0, 3'b000}, mk(0, 0, 0, 1, 3)};

        rst = 1'b1;
        drv_valid = 1'b0;
        drv_f = 3'b000;
        out_ready = 1'b0;
        sel = 0;
        prev_ac = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("reset_in_ready",  int'(obs_in_ready), 1);
        chk("reset_out_valid", int'(obs_out_valid), 0);
        chk("reset_gt",  int'(obs_gt), 0);
        chk("reset_err", int'(obs_err), 0);
        chk("reset_verdict", int'(obs_vd), 3);
        @(posedge clk);
        #1;

        for (int v = 0; v < 9; v++) begin
            sel = vt[v].sel;
            n = vt[v].n;
            out_ready = 1'b1;
            h0 = hs_cnt;
            exp_q.push_back(vt[v].e);
            for (int i = 0; i < n; i++) begin
                f = vt[v].f[3*i +: 3];
                send(f, ac);
                if (i == n - 2) chk("out_valid_before_last", int'(obs_out_valid), 0);
                if (i == n - 1) chk("out_valid_after_last", int'(obs_out_valid), 1);
            end
            chk("handshakes", hs_cnt - h0, n);
            if (sel == 2 && v > 0 && vt[v-1].sel == 2) chk("w1_spacing", ac - prev_ac, 2);
            prev_ac = ac;
            nsel = (v < 8) ? vt[(v < 8) ? v + 1 : v].sel : -1;
            if (nsel != sel) drain();
        end

        // Backpressure: report held while out_ready is low and in_valid is high.
        sel = 0;
        out_ready = 1'b0;
        exp_q.push_back(mk(4, 0, 4, 0, 1));
        for (int i = 0; i < 8; i++) send((i < 4) ? 3'b100 : 3'b001, ac);
        drv_f = 3'b010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_in_ready",  int'(obs_in_ready), 0);
            chk("bp_out_valid", int'(obs_out_valid), 1);
            chk("bp_gt", int'(obs_gt), 4);
            chk("bp_lt", int'(obs_lt), 4);
            chk("bp_verdict", int'(obs_vd), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        chk("bp_after_in_ready",  int'(obs_in_ready), 1);
        chk("bp_after_out_valid", int'(obs_out_valid), 0);
        chk("bp_after_gt", int'(obs_gt), 0);
        chk("bp_after_lt", int'(obs_lt), 0);
        chk("bp_after_verdict", int'(obs_vd), 3);
        chk("bp_report_taken", exp_q.size(), 0);
        exp_q.delete();

        // Reset in mid-window discards the partial window.
        for (int i = 0; i < 5; i++) send(3'b100, ac);
        rst = 1'b1;
        drv_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_gt", int'(obs_gt), 0);
        chk("rst_mid_in_ready", int'(obs_in_ready), 1);
        chk("rst_mid_out_valid", int'(obs_out_valid), 0);
        exp_q.push_back(mk(0, 8, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            send(3'b010, ac);
            if (i == 6) chk("rst_fresh_no_early_report", int'(obs_out_valid), 0);
            if (i == 7) chk("rst_fresh_report", int'(obs_out_valid), 1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/compare_window_stats.md
Name: compare_window_stats

Overview:
- Downstream stage of the 4-bit magnitude comparator. Consumes its one-hot result flags (greater / equal / less) as a valid/ready stream of samples.
- Accumulates per-outcome counts over a fixed window of samples, then presents one report record: three counts, an error count and a majority verdict.
- Used for self-checking benches and compare-statistics logic that sits after the comparator.

Parameters:
- CNT_W, 8, width of every count output. Legal range: 2..16.
- WINDOW, 8, samples per report. Legal range: 1..(2^CNT_W - 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  a sample is present on the a_* inputs.
- in_ready  output  1  block accepts a sample this cycle.
- a_greater  input  1  comparator A>B flag.
- a_equal  input  1  comparator A=B flag.
- a_less  input  1  comparator A<B flag.
- out_valid  output  1  report record valid.
- out_ready  input  1  consumer takes the report.
- gt_count  output  CNT_W  number of greater samples in the window.
- eq_count  output  CNT_W  number of equal samples in the window.
- lt_count  output  CNT_W  number of less samples in the window.
- err_count  output  CNT_W  number of samples whose flags were not exactly one-hot.
- verdict  output  2  majority outcome: 00 = equal, 01 = greater, 10 = less, 11 = no valid samples.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is rst, synchronous and active-high.
- Reset values: state = ACCUM, sample counter = 0, all counts = 0, out_valid = 0, verdict = 2'b11. in_ready is 1 from the first cycle after reset.
- Accept rule: a sample is accepted on a rising edge where in_valid && in_ready. in_ready = (state == ACCUM), decoded from registered state only, with no combinational path from in_valid or out_ready.
- Per accepted sample (exactly one counter updates, and the sample counter increments):
  - Flags 100 -> gt_count+1.
  - Flags 010 -> eq_count+1.
  - Flags 001 -> lt_count+1.
  - Any other pattern (000, 011, 111, ...) -> err_count+1 only.
- Counts never wrap: WINDOW <= 2^CNT_W - 1 guarantees this.
- State ACCUM:
  - out_valid = 0.
  - On acceptance of the WINDOW-th sample, move to REPORT.
  - Counts, including that final sample, and verdict are registered on the same edge.
  - out_valid rises on the cycle after the final sample handshake (1-cycle latency).
- State REPORT:
  - in_ready = 0, out_valid = 1.
  - All outputs are held stable until out_ready = 1.
  - On the out_ready edge: return to ACCUM and clear all counts and the sample counter on that same edge. verdict returns to 11, out_valid drops, and in_ready = 1 the next cycle.
  - out_ready while out_valid = 0 is ignored.
  - in_valid while in REPORT is ignored; the sample is not consumed.
- Verdict, computed on the final-sample edge from the final counts:
  - Largest of gt/eq/lt wins.
  - Ties resolve in priority equal > greater > less.
  - If gt = eq = lt = 0 (all samples erroneous), verdict = 11.
- Outputs during ACCUM reflect the running counts. Consumers only sample them when out_valid = 1.
- WINDOW = 1: every accepted sample produces a report. Throughput is 1 sample per 2 cycles when out_ready is held high.
- Reset in mid-window or mid-REPORT discards the partial or pending report and returns to the reset values on the next edge.
- Verification assertions:
  - Stability: while out_valid && !out_ready, every output is unchanged from the previous cycle.
  - Sum: at report time, gt + eq + lt + err = WINDOW.

Test Plan:
- WINDOW=8, 8 samples of flags 100 with in_valid held high, out_ready=1 -> exactly 8 handshakes; out_valid high 1 cycle after the 8th; gt=8, eq=0, lt=0, err=0, verdict=01.
- WINDOW=8, sample flags 010,100,010,001,100,010,001,001 -> gt=2, eq=3, lt=3, err=0; eq/lt tie resolves to verdict=00.
- WINDOW=8, 6 samples of 001 plus 2 samples of 000/110 -> lt=6, err=2, verdict=10. WINDOW=4, all 4 samples 111 -> err=4, verdict=11.
- Backpressure: report ready, out_ready held 0 for 5 cycles while in_valid=1 -> in_ready=0 and outputs stable throughout; on out_ready=1, counts are 0 and in_ready=1 the next cycle.
- rst asserted after 5 of 8 samples -> counts=0 next cycle; 8 fresh samples then required before out_valid.
- WINDOW=1, out_ready tied 1, 4 consecutive samples (100,010,001,000) -> 4 reports on alternate cycles with verdicts 01,00,10,11.
